axis_stim_gen: RTL and testbench

AXIS_STIM_GEN -- requirements
Module: axis_stim_gen

---
 rtl/stim_pkg.sv | 22 ++
 rtl/axis_if.sv | 14 +
 rtl/stim_lfsr.sv | 41 ++++
 rtl/axis_stim_gen.sv | 172 +++++++++++++++++
 tb/tb_axis_stim_gen.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stim_pkg.sv
// Shared types and constants for the AXI-Stream stimulus generator.
// Modes, FSM states and the PRBS tap mask live here.
package stim_pkg;

  typedef enum logic [1:0] {
    IMPULSE,
    STEP,
    RAMP,
    PRBS
  } stim_mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } stim_state_t;

  // x^32 + x^22 + x^2 + x + 1 -> feedback from bits 31, 21, 1, 0
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle: data, valid and ready.
// MST drives data/valid, SLV drives ready.
interface axis #(
  parameter int DW = 32
);

  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;

  modport MST (output tdata, output tvalid, input tready);
  modport SLV (input tdata, input tvalid, output tready);

endinterface

// File: rtl/stim_lfsr.sv
// 32-bit Fibonacci LFSR with seed load and step enable.
// Exposes its next-cycle value so callers can register derived data.
module stim_lfsr
  import stim_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  output logic [31:0] d
);

  logic [31:0] q_q;
  logic [31:0] q_d;
  logic [31:0] nxt;

  // shift left, feedback into bit 0; load wins over step
  always_comb begin
    nxt = {q_q[30:0], ^(q_q & LFSR_TAPS)};
    q_d = q_q;
    if (load) begin
      q_d = SEED;
    end else if (step) begin
      q_d = nxt;
    end
  end

  assign d = q_d;

  // LFSR state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/axis_stim_gen.sv
// Framed AXI-Stream test-pattern source: impulse, step, ramp, PRBS.
// tdata/tlast are computed from next-cycle state and registered.
module axis_stim_gen
  import stim_pkg::*;
#(
  parameter int          WIDTH         = 16,
  parameter int          MAX_CNT       = 64,
  parameter int          IMPULSE_PHASE = 49,
  parameter int          PULSE_VAL     = 1,
  parameter logic [31:0] LFSR_SEED     = 32'h0000_0001,
  parameter int          FRAME_CNT_WID = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic [FRAME_CNT_WID-1:0] nframes,
  axis.MST                         m_axis,
  output logic                     m_axis_tlast,
  output logic [FRAME_CNT_WID-1:0] frame_cnt,
  output logic                     busy,
  output logic                     done
);

  localparam int IW = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;
  localparam logic [IW-1:0] LAST  = IW'(MAX_CNT - 1);
  localparam logic [IW-1:0] PHASE = IW'(IMPULSE_PHASE);
  localparam logic [WIDTH-1:0] PV = WIDTH'(PULSE_VAL);

  stim_state_t state_q, state_d;
  stim_mode_t  mode_q, mode_d;

  logic [FRAME_CNT_WID-1:0] nfr_q, nfr_d;
  logic [FRAME_CNT_WID-1:0] frm_q, frm_d;
  logic [FRAME_CNT_WID-1:0] frm_inc;
  logic [IW-1:0]            idx_q, idx_d;
  logic [IW-1:0]            idx_nx;
  logic                     tvalid_q, tvalid_d;
  logic                     tlast_q, tlast_d;
  logic [2*WIDTH-1:0]       tdata_q, tdata_d;
  logic [WIDTH-1:0]         re, im;
  logic [31:0]              lfsr_d;
  logic                     lfsr_load;
  logic                     lfsr_step;
  logic                     fire;
  logic                     is_last;

  assign fire    = tvalid_q & m_axis.tready;
  assign is_last = (idx_q == LAST);
  assign idx_nx  = is_last ? '0 : idx_q + IW'(1);
  assign frm_inc = frm_q + FRAME_CNT_WID'(1);

  stim_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .d     (lfsr_d)
  );

  // run control: beat/frame advance on completion, state transitions
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    nfr_d     = nfr_q;
    idx_d     = idx_q;
    frm_d     = frm_q;
    tvalid_d  = tvalid_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    if (fire) begin
      idx_d     = idx_nx;
      lfsr_step = 1'b1;
      if (is_last) begin
        frm_d = frm_inc;
      end
    end
    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d   = S_RUN;
          mode_d    = stim_mode_t'(mode);
          nfr_d     = nframes;
          idx_d     = '0;
          frm_d     = '0;
          lfsr_load = 1'b1;
          tvalid_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (fire && is_last && (nfr_q != '0)
            && (frm_inc == nfr_q)) begin
          state_d  = S_DONE;
          tvalid_d = 1'b0;
        end else if (!en) begin
          if (fire && is_last) begin
            state_d  = S_IDLE;
            tvalid_d = 1'b0;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (fire && is_last) begin
          state_d  = S_IDLE;
          tvalid_d = 1'b0;
        end
      end
      S_DONE: begin
        if (!en) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        tvalid_d = 1'b0;
      end
    endcase
  end

  // pattern for the beat that will be on the bus next cycle
  always_comb begin
    re = '0;
    im = '0;
    unique case (mode_d)
      IMPULSE: if (idx_d == PHASE) re = PV;
      STEP:    if (idx_d >= PHASE) re = PV;
      RAMP: begin
        re = WIDTH'(idx_d);
        im = WIDTH'(frm_d);
      end
      PRBS:    {im, re} = lfsr_d[2*WIDTH-1:0];
      default: re = '0;
    endcase
    tdata_d = tvalid_d ? {im, re} : '0;
    tlast_d = tvalid_d & (idx_d == LAST);
  end

  // state, counters and registered stream outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= IMPULSE;
      nfr_q    <= '0;
      frm_q    <= '0;
      idx_q    <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      nfr_q    <= nfr_d;
      frm_q    <= frm_d;
      idx_q    <= idx_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign frame_cnt     = frm_q;
  assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_axis_stim_gen.sv
// Randomised bench for axis_stim_gen with a beat-level reference model.
// Stream beats are checked on every completion and while stalled.
module tb_axis_stim_gen;

  localparam int W   = 16;
  localparam int M   = 64;
  localparam int PH  = 49;
  localparam int FCW = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [1:0]     mode = 2'd0;
  logic [FCW-1:0] nframes = '0;
  logic           tlast;
  logic [FCW-1:0] frame_cnt;
  logic           busy;
  logic           done;
  logic           tready_drv = 1'b1;
  logic           ready_rand = 1'b0;

  axis #(.DW(2*W)) m_axis ();
  assign m_axis.tready = tready_drv;

  axis_stim_gen #(
    .WIDTH         (W),
    .MAX_CNT       (M),
    .IMPULSE_PHASE (PH),
    .PULSE_VAL     (1),
    .LFSR_SEED     (32'h0000_0001),
    .FRAME_CNT_WID (FCW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .mode         (mode),
    .nframes      (nframes),
    .m_axis       (m_axis),
    .m_axis_tlast (tlast),
    .frame_cnt    (frame_cnt),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    tready_drv = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // reference model: one entry per beat of the sequence
  logic        model_on = 1'b0;
  int          exp_mode;
  int          exp_idx;
  int          exp_frame;
  logic [31:0] exp_lfsr;
  int          beats = 0;
  int          stalls = 0;
  int          imp_q[$];
  int          last_q[$];
  logic [31:0] first_q[$];

  function automatic logic [31:0] lfsr_next(logic [31:0] x);
    return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

  function automatic logic [31:0] exp_data();
    case (exp_mode)
      0:       return (exp_idx == PH) ? 32'd1 : 32'd0;
      1:       return (exp_idx >= PH) ? 32'd1 : 32'd0;
      2:       return {16'(exp_frame), 16'(exp_idx)};
      default: return exp_lfsr;
    endcase
  endfunction

  task automatic model_start(int md);
    exp_mode  = md;
    exp_idx   = 0;
    exp_frame = 0;
    exp_lfsr  = 32'h0000_0001;
    beats     = 0;
    imp_q.delete();
    last_q.delete();
    first_q.delete();
    model_on  = 1'b1;
  endtask

  logic        pend = 1'b0;
  logic [31:0] pend_d;
  logic        pend_l;

  // beats presented at a falling edge complete at the next rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("stall_valid", m_axis.tvalid, 1);
        chk("stall_data", m_axis.tdata, pend_d);
        chk("stall_last", tlast, pend_l);
      end
      pend = 1'b0;
      if (m_axis.tvalid && model_on) begin
        if (m_axis.tready) begin
          chk("beat_data", m_axis.tdata, exp_data());
          chk("beat_last", tlast, exp_idx == M - 1);
          if (exp_mode == 0 && m_axis.tdata != 0) imp_q.push_back(beats);
          if (tlast) last_q.push_back(beats);
          if (first_q.size() < 5) first_q.push_back(m_axis.tdata);
          beats++;
          exp_lfsr = lfsr_next(exp_lfsr);
          if (exp_idx == M - 1) begin
            exp_idx = 0;
            exp_frame++;
          end else begin
            exp_idx++;
          end
        end else begin
          pend   = 1'b1;
          pend_d = m_axis.tdata;
          pend_l = tlast;
          stalls++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_beats(int n, int budget, string nm);
    int c = 0;
    while (beats < n && c < budget) begin
      tick();
      c++;
    end
    if (beats < n) chk(nm, beats, n);
  endtask

  task automatic wait_done(int budget, string nm);
    int c = 0;
    while (!done && c < budget) begin
      tick();
      c++;
    end
    if (!done) chk(nm, done, 1);
  endtask

  task automatic wait_idle(int budget, string nm);
    int c = 0;
    while ((busy || done) && c < budget) begin
      tick();
      c++;
    end
    if (busy || done) chk(nm, busy, 0);
  endtask

  function automatic longint qi(int q[$], int i);
    return (q.size() > i) ? longint'(q[i]) : -1;
  endfunction

  function automatic longint qd(logic [31:0] q[$], int i);
    return (q.size() > i) ? longint'(q[i]) : -1;
  endfunction

  initial begin
    repeat (3) tick();
    chk("rst_tvalid", m_axis.tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", m_axis.tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    tick();

    // impulse, two frames
    mode = 2'd0;
    nframes = 16'd2;
    model_start(0);
    en = 1'b1;
    chk("valid_before_edge", m_axis.tvalid, 0);
    @(posedge clk);
    #1;
    chk("valid_after_edge", m_axis.tvalid, 1);
    wait_done(300, "imp_done_timeout");
    chk("imp_beats", beats, 128);
    chk("imp_hits", imp_q.size(), 2);
    chk("imp_hit0", qi(imp_q, 0), 49);
    chk("imp_hit1", qi(imp_q, 1), 113);
    chk("imp_lasts", last_q.size(), 2);
    chk("imp_last0", qi(last_q, 0), 63);
    chk("imp_last1", qi(last_q, 1), 127);
    chk("imp_done", done, 1);
    chk("imp_frame_cnt", frame_cnt, 2);
    chk("imp_valid_off", m_axis.tvalid, 0);
    repeat (5) tick();
    chk("imp_hold_done", done, 1);
    chk("imp_no_restart", beats, 128);
    en = 1'b0;
    tick();
    tick();
    chk("imp_idle_done", done, 0);
    chk("imp_idle_busy", busy, 0);

    // ramp under random backpressure
    ready_rand = 1'b1;
    mode = 2'd2;
    nframes = 16'd3;
    model_start(2);
    stalls = 0;
    en = 1'b1;
    wait_done(2000, "bp_done_timeout");
    chk("bp_beats", beats, 192);
    chk("bp_frame_cnt", frame_cnt, 3);
    chk("bp_lasts", last_q.size(), 3);
    chk("bp_stalls_seen", stalls > 0, 1);
    en = 1'b0;
    ready_rand = 1'b0;
    wait_idle(20, "bp_idle_timeout");

    // continuous step, early stop
    mode = 2'd1;
    nframes = 16'd0;
    model_start(1);
    en = 1'b1;
    wait_beats(21, 100, "es_beat_timeout");
    en = 1'b0;
    wait_idle(200, "es_idle_timeout");
    repeat (3) tick();
    chk("es_beats", beats, 64);
    chk("es_lasts", last_q.size(), 1);
    chk("es_last0", qi(last_q, 0), 63);
    chk("es_valid", m_axis.tvalid, 0);
    chk("es_busy", busy, 0);
    chk("es_done", done, 0);
    chk("es_frame_cnt", frame_cnt, 1);

    // PRBS, four frames then a one-frame rerun
    mode = 2'd3;
    nframes = 16'd4;
    model_start(3);
    en = 1'b1;
    wait_done(400, "prbs_done_timeout");
    chk("prbs_beats", beats, 256);
    chk("prbs_b0", qd(first_q, 0), 32'h1);
    chk("prbs_b1", qd(first_q, 1), 32'h3);
    chk("prbs_b2", qd(first_q, 2), 32'h6);
    chk("prbs_b3", qd(first_q, 3), 32'hD);
    chk("prbs_b4", qd(first_q, 4), 32'h1B);
    en = 1'b0;
    wait_idle(20, "prbs_idle_timeout");
    nframes = 16'd1;
    model_start(3);
    en = 1'b1;
    wait_done(100, "prbs2_done_timeout");
    chk("prbs2_beats", beats, 64);
    chk("prbs2_b0", qd(first_q, 0), 32'h1);
    chk("prbs2_b1", qd(first_q, 1), 32'h3);
    en = 1'b0;
    wait_idle(20, "prbs2_idle_timeout");

    // reset in the middle of a frame
    mode = 2'd2;
    nframes = 16'd0;
    model_start(2);
    en = 1'b1;
    wait_beats(30, 100, "rs_beat_timeout");
    rst_n = 1'b0;
    model_on = 1'b0;
    #1;
    chk("rs_tvalid", m_axis.tvalid, 0);
    chk("rs_tlast", tlast, 0);
    chk("rs_busy", busy, 0);
    chk("rs_frame_cnt", frame_cnt, 0);
    tick();
    tick();
    model_start(2);
    rst_n = 1'b1;
    wait_beats(5, 20, "rs_restart_timeout");
    chk("rs_first0", qd(first_q, 0), 32'h0);
    chk("rs_first1", qd(first_q, 1), 32'h1);
    en = 1'b0;
    wait_idle(200, "rs_idle_timeout");

    // single frame, mode change mid-run, en falls on final tlast
    mode = 2'd0;
    nframes = 16'd1;
    model_start(0);
    en = 1'b1;
    wait_beats(10, 50, "bd_beat_timeout");
    mode = 2'd3;
    nframes = 16'd5;
    wait_beats(64, 100, "bd_last_timeout");
    en = 1'b0;
    tick();
    chk("bd_done", done, 1);
    chk("bd_busy", busy, 0);
    chk("bd_valid", m_axis.tvalid, 0);
    chk("bd_frame_cnt", frame_cnt, 1);
    tick();
    chk("bd_idle_done", done, 0);
    chk("bd_idle_busy", busy, 0);
    chk("bd_beats", beats, 64);
    chk("bd_hits", imp_q.size(), 1);
    chk("bd_hit0", qi(imp_q, 0), 49);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
